// File: rtl/udp_buf_pkg.sv
// Shared types for the UDP loopback packet buffer: the queued packet descriptor
// and the transmit-side state encoding.
package udp_buf_pkg;

  localparam int START_W = 16;

  typedef struct packed {
    logic [START_W-1:0] start;
    logic [15:0]        len;
    logic [47:0]        mac;
    logic [31:0]        ip;
    logic [15:0]        port;
  } desc_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_BUSY  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/udp_buf_ram.sv
// Simple dual-port byte RAM with a registered read port; the read port has no
// reset so the array maps onto a single block RAM.
module udp_buf_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_pkt_buffer.sv
// Store-and-forward buffer between the UDP rx parser and the tx framer.
// state    | meaning
// TX_IDLE  | waiting for a committed descriptor
// TX_START | one-cycle tx_start pulse, header outputs loaded
// TX_BUSY  | serving byte requests until the framer reports tx_done
module udp_pkt_buffer
  import udp_buf_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DESC_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_done,
  input  logic        in_err,
  input  logic [15:0] in_len,
  input  logic [47:0] in_mac,
  input  logic [31:0] in_ip,
  input  logic [15:0] in_port,
  output logic        in_overflow,
  output logic        tx_start,
  input  logic        tx_done,
  output logic [15:0] tx_len,
  output logic [47:0] tx_mac,
  output logic [31:0] tx_ip,
  output logic [15:0] tx_port,
  input  logic        tx_req,
  output logic [7:0]  tx_data,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
);

  localparam int NDESC = 2**DESC_W;

  logic [ADDR_W-1:0] wr_ptr, commit_ptr, rd_base, rd_ptr, used, wr_ptr_nxt;
  logic [15:0]       byte_cnt, byte_cnt_nxt, req_cnt;
  logic              drop_flag, first_byte, drop_first, room, wr_en, drop_now, reject;

  desc_t             desc_mem [NDESC];
  desc_t             desc_head, desc_new;
  logic [DESC_W:0]   desc_wr, desc_rd;
  logic              desc_full, desc_empty, desc_push, desc_pop;

  tx_state_e         state;
  logic              rd_en, rd_sel;
  logic [7:0]        ram_q;

  // ---------------- write side ----------------
  assign used       = wr_ptr - rd_base;
  assign room       = (used != {ADDR_W{1'b1}});
  assign first_byte = in_valid && !drop_flag && (byte_cnt == 16'd0);
  assign drop_first = first_byte && desc_full;
  assign wr_en      = in_valid && !drop_flag && !drop_first && room;
  assign drop_now   = drop_flag || drop_first || (in_valid && !room);

  // A byte arriving together with in_done is counted before the done check.
  assign wr_ptr_nxt   = wr_en ? wr_ptr + ADDR_W'(1) : wr_ptr;
  assign byte_cnt_nxt = wr_en ? byte_cnt + 16'd1 : byte_cnt;
  assign reject       = drop_now || in_err || (byte_cnt_nxt == 16'd0) ||
                        (byte_cnt_nxt != in_len);
  assign desc_push    = in_done && !reject;
  assign desc_new     = '{start: START_W'(commit_ptr), len: byte_cnt_nxt,
                          mac: in_mac, ip: in_ip, port: in_port};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      byte_cnt   <= '0;
      drop_flag  <= 1'b0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else if (in_done) begin
      byte_cnt  <= '0;
      drop_flag <= 1'b0;
      if (reject) begin
        wr_ptr   <= commit_ptr;
        drop_cnt <= drop_cnt + 16'd1;
      end else begin
        wr_ptr     <= wr_ptr_nxt;
        commit_ptr <= wr_ptr_nxt;
        pkt_cnt    <= pkt_cnt + 16'd1;
      end
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      byte_cnt  <= byte_cnt_nxt;
      drop_flag <= drop_now;
    end
  end

  assign in_overflow = drop_flag;

  // ---------------- descriptor FIFO ----------------
  assign desc_empty = (desc_wr == desc_rd);
  assign desc_full  = (desc_wr[DESC_W] != desc_rd[DESC_W]) &&
                      (desc_wr[DESC_W-1:0] == desc_rd[DESC_W-1:0]);
  assign desc_head  = desc_mem[desc_rd[DESC_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_wr <= '0;
      desc_rd <= '0;
    end else begin
      if (desc_push) desc_wr <= desc_wr + (DESC_W+1)'(1);
      if (desc_pop)  desc_rd <= desc_rd + (DESC_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (desc_push) desc_mem[desc_wr[DESC_W-1:0]] <= desc_new;
  end

  // ---------------- byte RAM ----------------
  udp_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  // ---------------- transmit side ----------------
  assign rd_en    = (state == TX_BUSY) && tx_req && (req_cnt < tx_len);
  assign desc_pop = (state == TX_BUSY) && tx_done;
  assign tx_data  = rd_sel ? ram_q : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      tx_start <= 1'b0;
      tx_len   <= '0;
      tx_mac   <= '0;
      tx_ip    <= '0;
      tx_port  <= '0;
      rd_ptr   <= '0;
      req_cnt  <= '0;
      rd_base  <= '0;
      rd_sel   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      rd_sel   <= rd_en;
      case (state)
        TX_IDLE: begin
          if (!desc_empty) begin
            tx_len   <= desc_head.len;
            tx_mac   <= desc_head.mac;
            tx_ip    <= desc_head.ip;
            tx_port  <= desc_head.port;
            rd_ptr   <= desc_head.start[ADDR_W-1:0];
            req_cnt  <= '0;
            tx_start <= 1'b1;
            state    <= TX_START;
          end
        end
        TX_START: state <= TX_BUSY;
        TX_BUSY: begin
          if (rd_en) begin
            rd_ptr  <= rd_ptr + ADDR_W'(1);
            req_cnt <= req_cnt + 16'd1;
          end
          // Retire the whole packet even if the framer read only part of it.
          if (tx_done) begin
            rd_base <= ADDR_W'(desc_head.start + desc_head.len);
            state   <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_pkt_buffer.sv
// Randomized scoreboard bench for udp_pkt_buffer (DEPTH=64, 4 descriptors).
module tb_udp_pkt_buffer;

  localparam int ADDR_W = 6;
  localparam int DESC_W = 2;
  localparam int DEPTH  = 64;
  localparam int NDESC  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_done, in_err;
  logic [7:0]  in_data;
  logic [15:0] in_len, in_port;
  logic [47:0] in_mac;
  logic [31:0] in_ip;
  logic        in_overflow, tx_start, tx_done, tx_req;
  logic [15:0] tx_len, tx_port, pkt_cnt, drop_cnt;
  logic [47:0] tx_mac;
  logic [31:0] tx_ip;
  logic [7:0]  tx_data;

  always #4 clk = ~clk;

  udp_pkt_buffer #(.ADDR_W(ADDR_W), .DESC_W(DESC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_done(in_done), .in_err(in_err),
    .in_len(in_len), .in_mac(in_mac), .in_ip(in_ip), .in_port(in_port),
    .in_overflow(in_overflow),
    .tx_start(tx_start), .tx_done(tx_done), .tx_len(tx_len), .tx_mac(tx_mac),
    .tx_ip(tx_ip), .tx_port(tx_port), .tx_req(tx_req), .tx_data(tx_data),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [15:0] len;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
  } hdr_t;

  // Reference model: committed-but-not-retired packets in order.
  hdr_t       sb_hdr[$];
  logic [7:0] sb_data[$];
  int errors = 0, checks = 0;
  int exp_pkt = 0, exp_drop = 0;
  int cyc = 0;
  bit tx_enable = 0, abort = 0, tx_seen = 0, force_extra = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int committed_bytes();
    int s = 0;
    foreach (sb_hdr[i]) s += int'(sb_hdr[i].len);
    return s;
  endfunction

  function automatic hdr_t rand_hdr();
    hdr_t h;
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    h.len  = '0;
    h.mac  = r[47:0];
    h.ip   = $urandom();
    h.port = 16'($urandom());
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input int len_field, input bit err,
                          input hdr_t h, input bit rand_gap);
    int committed;
    bit drop_first, accept, together;
    logic [7:0] bytes[$];
    hdr_t hh;
    committed  = committed_bytes();
    drop_first = (sb_hdr.size() == NDESC) && (n > 0);
    accept     = !drop_first && (committed + n <= DEPTH - 1) && !err &&
                 (n > 0) && (n == len_field);
    together   = (n > 0) && ($urandom_range(0, 1) == 1);
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom()));
    if (accept) begin
      hh = h;
      hh.len = 16'(n);
      sb_hdr.push_back(hh);
      foreach (bytes[i]) sb_data.push_back(bytes[i]);
      exp_pkt++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < n; i++) begin
      if (rand_gap) repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_data  = bytes[i];
      if (together && i == n - 1) begin
        in_done = 1'b1; in_err = err; in_len = 16'(len_field);
        in_mac = h.mac; in_ip = h.ip; in_port = h.port;
      end
      tick();
      in_valid = 1'b0;
      if (!(together && i == n - 1))
        check("in_overflow_byte", in_overflow,
              (drop_first || (committed + i >= DEPTH - 1)) ? 1 : 0);
    end
    if (!together) begin
      in_done = 1'b1; in_err = err; in_len = 16'(len_field);
      in_mac = h.mac; in_ip = h.ip; in_port = h.port;
      tick();
    end
    in_done = 1'b0;
    in_err  = 1'b0;
    check("in_overflow_after_done", in_overflow, 0);
    check("pkt_cnt", pkt_cnt, 16'(exp_pkt));
    check("drop_cnt", drop_cnt, 16'(exp_drop));
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_hdr.size() != 0 && t < 5000) begin
      tick();
      t++;
    end
    check("drain_timeout", 64'(sb_hdr.size()), 0);
  endtask

  task automatic safe_send(input int n, input int len_field, input bit err,
                           input hdr_t h, input bit rand_gap);
    if (!(sb_hdr.size() < NDESC && committed_bytes() + n <= DEPTH - 1)) wait_drain();
    send_pkt(n, len_field, err, h, rand_gap);
  endtask

  // Framer model / monitor: pops the scoreboard whenever the DUT starts a frame.
  initial begin : framer
    hdr_t h;
    int nreq, mode, last_done;
    logic [7:0] exp_b;
    last_done = -1000;
    tx_req  = 1'b0;
    tx_done = 1'b0;
    forever begin
      tick();
      if (tx_start && !rst) begin
        tx_seen = 1;
        if (sb_hdr.size() == 0) begin
          check("unexpected_tx_start", 1, 0);
        end else begin
          h = sb_hdr[0];
          check("start_gap_ok", (cyc - last_done >= 2) ? 1 : 0, 1);
          check("tx_len", tx_len, h.len);
          check("tx_mac", tx_mac, h.mac);
          check("tx_ip", tx_ip, h.ip);
          check("tx_port", tx_port, h.port);
          tick();
          while (!tx_enable && !abort) tick();
          if (!abort) begin
            mode = $urandom_range(0, 7);
            if (force_extra || mode == 0) nreq = int'(h.len) + 1;
            else if (mode == 1)           nreq = int'(h.len) / 2;
            else                          nreq = int'(h.len);
            for (int i = 0; i < nreq; i++) begin
              repeat ($urandom_range(0, 1)) tick();
              tx_req = 1'b1;
              tick();
              tx_req = 1'b0;
              exp_b = (i < int'(h.len)) ? sb_data[i] : 8'h00;
              check("tx_data", tx_data, exp_b);
            end
            check("tx_len_stable", tx_len, h.len);
            tx_done = 1'b1;
            last_done = cyc;
            tick();
            tx_done = 1'b0;
            void'(sb_hdr.pop_front());
            repeat (int'(h.len)) void'(sb_data.pop_front());
          end
        end
      end
    end
  end

  initial begin : stim
    hdr_t h;
    int n, lf, t;
    bit err;
    rst = 1'b1;
    in_valid = 0; in_done = 0; in_err = 0; in_data = '0;
    in_len = '0; in_mac = '0; in_ip = '0; in_port = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_overflow", in_overflow, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_len", tx_len, 0);
    check("rst_tx_mac", tx_mac, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    tick();
    tx_enable = 1;

    // 18-byte reference packet
    h = '{len: 16'd0, mac: 48'h001122334455, ip: 32'hc0a80003, port: 16'd6000};
    send_pkt(18, 18, 0, h, 0);
    wait_drain();

    // errored packet followed by a good one reusing the rolled-back space
    send_pkt(10, 10, 1, rand_hdr(), 1);
    safe_send(4, 4, 0, rand_hdr(), 0);
    wait_drain();

    // length mismatch and empty packet
    send_pkt(5, 6, 0, rand_hdr(), 0);
    send_pkt(0, 0, 0, rand_hdr(), 0);

    // overflow with the framer stalled
    tx_enable = 0;
    send_pkt(80, 80, 0, rand_hdr(), 0);

    // descriptor FIFO full: four commit, fifth drops
    for (int i = 0; i < 5; i++) send_pkt(8, 8, 0, rand_hdr(), 0);
    tx_enable = 1;
    wait_drain();

    // address wrap with repeated 20-byte packets, each with one extra request
    force_extra = 1;
    for (int i = 0; i < 8; i++) safe_send(20, 20, 0, rand_hdr(), $urandom_range(0, 1));
    wait_drain();
    force_extra = 0;

    // random traffic
    for (int i = 0; i < 40; i++) begin
      n   = $urandom_range(0, 24);
      err = ($urandom_range(0, 7) == 0);
      lf  = ($urandom_range(0, 7) == 0) ? n + 1 : n;
      safe_send(n, lf, err, rand_hdr(), $urandom_range(0, 1));
    end
    wait_drain();

    // reset while the framer holds the buffer in BUSY
    tx_enable = 0;
    tx_seen = 0;
    send_pkt(12, 12, 0, rand_hdr(), 0);
    t = 0;
    while (!tx_seen && t < 100) begin tick(); t++; end
    check("tx_seen_before_reset", tx_seen, 1);
    repeat (3) tick();
    abort = 1;
    rst = 1'b1;
    tick();
    tick();
    check("midrst_tx_start", tx_start, 0);
    check("midrst_tx_len", tx_len, 0);
    check("midrst_tx_ip", tx_ip, 0);
    check("midrst_tx_port", tx_port, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_pkt_cnt", pkt_cnt, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    sb_hdr.delete();
    sb_data.delete();
    exp_pkt = 0;
    exp_drop = 0;
    rst = 1'b0;
    repeat (30) tick();
    abort = 0;
    check("post_rst_pkt_cnt", pkt_cnt, 0);

    // buffer works normally after the reset
    tx_enable = 1;
    send_pkt(7, 7, 0, rand_hdr(), 1);
    wait_drain();
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
